mem_rr_scheduler: RTL

//  N-port round-robin scheduler in front of the single iomem port. Each requester (icache, dcache,

---
 rtl/mem_rr_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_rr_scheduler.sv
// Round-robin scheduler placing NUM_REQ one-entry request slots onto the single iomem port.
// Latency: slot capture edge 0, grant edge 1, mem_valid_o from cycle after edge 1; response combinational in WAIT.
// Backpressure: a port stalls while its slot is full; ISSUE holds the request stable until mem_ready_i.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o            per-port offer / slot-empty handshake
//   req_addr_i/req_wdata_i/req_be_i    per-port request fields, port i at [i*W +: W]
//   res_valid_o/res_err_o/res_rdata_o  one-hot response pulse, timeout flag, shared response data
//   mem_valid_o/mem_ready_i            request handshake towards memory
//   mem_addr_o/mem_wdata_o/mem_be_o    request fields of the granted slot (zero when not issuing)
//   mem_rvalid_i/mem_rdata_i           memory response / write ack
//   busy_o                             a transaction is being issued or awaited
module mem_rr_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int BE_W    = DATA_W / 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  input  logic [NUM_REQ*BE_W-1:0]   req_be_i,
  output logic [NUM_REQ-1:0]        res_valid_o,
  output logic [NUM_REQ-1:0]        res_err_o,
  output logic [DATA_W-1:0]         res_rdata_o,
  output logic                      mem_valid_o,
  input  logic                      mem_ready_i,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  output logic [BE_W-1:0]           mem_be_o,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic                      busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   next_ptr;
  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [WD_W-1:0]    wdog;

  logic [NUM_REQ-1:0] slot_vld;
  logic [ADDR_W-1:0]  slot_addr  [NUM_REQ];
  logic [DATA_W-1:0]  slot_wdata [NUM_REQ];
  logic [BE_W-1:0]    slot_be    [NUM_REQ];

  logic               rsp_fire;
  logic               wd_expire;
  logic               retire;

  // A real response on the final watchdog cycle takes priority over the error.
  assign rsp_fire  = (state == ST_WAIT) && mem_rvalid_i;
  assign wd_expire = (state == ST_WAIT) && (wdog == WD_W'(TIMEOUT - 1));
  assign retire    = rsp_fire || wd_expire;

  assign next_ptr  = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);

  // First occupied slot at or after rr_ptr, wrapping. Only slots take part,
  // so a same-cycle offer on req_valid_i cannot win a grant.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_vld && slot_vld[idx]) begin
        pick_vld = 1'b1;
        pick     = IDX_W'(idx);
      end
    end
  end

  // Slots: capture when empty, clear when the owner's response retires.
  // Ready is low while full, so a retiring slot cannot refill in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_vld <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
        slot_be[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid_i[i] && !slot_vld[i]) begin
          slot_vld[i]   <= 1'b1;
          slot_addr[i]  <= req_addr_i[i*ADDR_W +: ADDR_W];
          slot_wdata[i] <= req_wdata_i[i*DATA_W +: DATA_W];
          slot_be[i]    <= req_be_i[i*BE_W +: BE_W];
        end else if (retire && (grant == IDX_W'(i))) begin
          slot_vld[i]   <= 1'b0;
        end
      end
    end
  end

  // Transaction FSM; mem_rvalid_i outside WAIT is ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      wdog   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant <= pick;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ready_i) begin
            wdog  <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (retire) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end else begin
            wdog   <= wdog + WD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = ~slot_vld;
  assign busy_o      = (state != ST_IDLE);
  assign mem_valid_o = (state == ST_ISSUE);
  assign mem_addr_o  = mem_valid_o ? slot_addr[grant]  : '0;
  assign mem_wdata_o = mem_valid_o ? slot_wdata[grant] : '0;
  assign mem_be_o    = mem_valid_o ? slot_be[grant]    : '0;
  assign res_rdata_o = rsp_fire ? mem_rdata_i : '0;

  always_comb begin
    res_valid_o = '0;
    res_err_o   = '0;
    if (retire) res_valid_o[grant] = 1'b1;
    if (wd_expire && !mem_rvalid_i) res_err_o[grant] = 1'b1;
  end

endmodule
